prim_index_buffer: RTL and testbench

Parametrised vertex-index store with a built-in primitive assembly engine. It replaces the flat 48-bit-per-triangle edge store. Memory now holds individual IW-bit indices. On a START command, a fetch FSM walks a range of the memory and emits one packed triangle per valid/ready handshake, in list, strip or fan topology, to the rasteriser setup stage.

---
 rtl/prim_index_buffer.sv | 250 +++++++++++++++++++++++++
 tb/tb_prim_index_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_index_buffer.sv
// rtl/prim_index_buffer.sv - vertex-index store with list/strip/fan primitive assembly
//
// Holds DEPTH indices of IW bits in a single-read-port block RAM loaded by the
// host. A START command in IDLE latches MODE/BASE/COUNT. The fetch engine then
// walks (BASE + n) mod DEPTH and hands out one packed triangle per TRI_VALID /
// TRI_READY handshake.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   WR_EN, WR_ADDR, WR_DATA     host load port, accepted in every state
//   START, MODE, BASE, COUNT    assembly command, sampled only in IDLE
//   BUSY                        assembly in progress
//   TRI_VALID, TRI_READY        triangle handshake
//   TRI_DATA, TRI_LAST          {v2, v1, v0} and final-triangle flag
//   DONE                        one-cycle pulse when the range is finished

module prim_index_buffer #(
    parameter int DEPTH = 1024,
    parameter int IW    = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WR_EN,
    input  logic [AW-1:0]   WR_ADDR,
    input  logic [IW-1:0]   WR_DATA,
    input  logic            START,
    input  logic [1:0]      MODE,
    input  logic [AW-1:0]   BASE,
    input  logic [AW:0]     COUNT,
    output logic            BUSY,
    output logic            TRI_VALID,
    input  logic            TRI_READY,
    output logic [3*IW-1:0] TRI_DATA,
    output logic            TRI_LAST,
    output logic            DONE
);

    localparam logic [1:0] MODE_LIST  = 2'd0;
    localparam logic [1:0] MODE_STRIP = 2'd1;
    localparam logic [1:0] MODE_FAN   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT,
        ST_FIN
    } state_e;

    logic [IW-1:0] mem [DEPTH];

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW:0]     tri_total_q, tri_total_d;
    logic [AW:0]     tri_k_q, tri_k_d;
    logic [AW:0]     rd_off_q, rd_off_d;
    logic [1:0]      reads_left_q, reads_left_d;
    logic [1:0]      caps_left_q, caps_left_d;
    logic            cap_first_q, cap_first_d;
    logic [IW-1:0]   h0_q, h0_d;
    logic [IW-1:0]   h1_q, h1_d;
    logic [IW-1:0]   fan0_q, fan0_d;
    logic            tri_valid_q, tri_valid_d;
    logic            tri_last_q, tri_last_d;
    logic [3*IW-1:0] tri_data_q, tri_data_d;
    logic            rvalid_q;
    logic [IW-1:0]   rdata_q;

    logic            ren;
    logic [AW-1:0]   raddr;
    logic [AW:0]     cnt_clamped;
    logic [AW:0]     start_tris;

    // Triangle count of the command currently on the inputs.
    always_comb begin
        cnt_clamped = (COUNT > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : COUNT;
        start_tris  = '0;
        case (MODE)
            MODE_LIST:           start_tris = cnt_clamped / (AW+1)'(3);
            MODE_STRIP, MODE_FAN: begin
                if (cnt_clamped >= (AW+1)'(3)) begin
                    start_tris = cnt_clamped - (AW+1)'(2);
                end
            end
            default:             start_tris = '0;
        endcase
    end

    // h0/h1 always hold the two most recently captured indices i[n-2], i[n-1]
    // and fan0 holds i[0]; every triangle is formed from those plus the index
    // arriving from the RAM in the completing cycle.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        base_d       = base_q;
        tri_total_d  = tri_total_q;
        tri_k_d      = tri_k_q;
        rd_off_d     = rd_off_q;
        reads_left_d = reads_left_q;
        caps_left_d  = caps_left_q;
        cap_first_d  = cap_first_q;
        h0_d         = h0_q;
        h1_d         = h1_q;
        fan0_d       = fan0_q;
        tri_valid_d  = tri_valid_q;
        tri_last_d   = tri_last_q;
        tri_data_d   = tri_data_q;
        ren          = 1'b0;
        raddr        = base_q + rd_off_q[AW-1:0];

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    mode_d      = MODE;
                    base_d      = BASE;
                    tri_total_d = start_tris;
                    tri_k_d     = '0;
                    if (start_tris != '0) begin
                        // The first read goes out on the START edge itself.
                        ren          = 1'b1;
                        raddr        = BASE;
                        rd_off_d     = (AW+1)'(1);
                        reads_left_d = 2'd2;
                        caps_left_d  = 2'd3;
                        cap_first_d  = 1'b1;
                        state_d      = ST_FETCH;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FETCH: begin
                if (reads_left_q != 2'd0) begin
                    ren          = 1'b1;
                    rd_off_d     = rd_off_q + (AW+1)'(1);
                    reads_left_d = reads_left_q - 2'd1;
                end
                if (rvalid_q) begin
                    h0_d        = h1_q;
                    h1_d        = rdata_q;
                    cap_first_d = 1'b0;
                    if (cap_first_q) begin
                        fan0_d = rdata_q;
                    end
                    caps_left_d = caps_left_q - 2'd1;
                    if (caps_left_q == 2'd1) begin
                        tri_valid_d = 1'b1;
                        tri_last_d  = (tri_k_q == tri_total_q - (AW+1)'(1));
                        case (mode_q)
                            MODE_STRIP: tri_data_d = tri_k_q[0] ? {rdata_q, h0_q, h1_q}
                                                                : {rdata_q, h1_q, h0_q};
                            MODE_FAN:   tri_data_d = {rdata_q, h1_q, fan0_q};
                            default:    tri_data_d = {rdata_q, h1_q, h0_q};
                        endcase
                        state_d = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                if (TRI_READY) begin
                    tri_valid_d = 1'b0;
                    if (tri_last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        // Start the next fetch on the handshake edge so strip/fan
                        // reach one triangle every two cycles.
                        tri_k_d  = tri_k_q + (AW+1)'(1);
                        ren      = 1'b1;
                        rd_off_d = rd_off_q + (AW+1)'(1);
                        if (mode_q == MODE_LIST) begin
                            reads_left_d = 2'd2;
                            caps_left_d  = 2'd3;
                        end else begin
                            reads_left_d = 2'd0;
                            caps_left_d  = 2'd1;
                        end
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_LIST;
            base_q       <= '0;
            tri_total_q  <= '0;
            tri_k_q      <= '0;
            rd_off_q     <= '0;
            reads_left_q <= 2'd0;
            caps_left_q  <= 2'd0;
            cap_first_q  <= 1'b0;
            h0_q         <= '0;
            h1_q         <= '0;
            fan0_q       <= '0;
            tri_valid_q  <= 1'b0;
            tri_last_q   <= 1'b0;
            tri_data_q   <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            base_q       <= base_d;
            tri_total_q  <= tri_total_d;
            tri_k_q      <= tri_k_d;
            rd_off_q     <= rd_off_d;
            reads_left_q <= reads_left_d;
            caps_left_q  <= caps_left_d;
            cap_first_q  <= cap_first_d;
            h0_q         <= h0_d;
            h1_q         <= h1_d;
            fan0_q       <= fan0_d;
            tri_valid_q  <= tri_valid_d;
            tri_last_q   <= tri_last_d;
            tri_data_q   <= tri_data_d;
            rvalid_q     <= ren;
        end
    end

    // Index RAM: contents survive reset; a same-address read and write in one
    // cycle returns the old value.
    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            mem[WR_ADDR] <= WR_DATA;
        end
        if (ren) begin
            rdata_q <= mem[raddr];
        end
    end

    assign BUSY      = (state_q == ST_FETCH) || (state_q == ST_EMIT);
    assign DONE      = (state_q == ST_FIN);
    assign TRI_VALID = tri_valid_q;
    assign TRI_DATA  = tri_data_q;
    assign TRI_LAST  = tri_last_q;

endmodule

// File: tb/tb_prim_index_buffer.sv
// tb/tb_prim_index_buffer.sv - self-checking bench for prim_index_buffer
module tb_prim_index_buffer;

    localparam int DEPTH = 1024;
    localparam int IW    = 16;
    localparam int AW    = 10;

    logic            CLK = 1'b0;
    logic            RST;
    logic            WR_EN;
    logic [AW-1:0]   WR_ADDR;
    logic [IW-1:0]   WR_DATA;
    logic            START;
    logic [1:0]      MODE;
    logic [AW-1:0]   BASE;
    logic [AW:0]     COUNT;
    logic            BUSY;
    logic            TRI_VALID;
    logic            TRI_READY;
    logic [3*IW-1:0] TRI_DATA;
    logic            TRI_LAST;
    logic            DONE;

    prim_index_buffer #(.DEPTH(DEPTH), .IW(IW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .START     (START),
        .MODE      (MODE),
        .BASE      (BASE),
        .COUNT     (COUNT),
        .BUSY      (BUSY),
        .TRI_VALID (TRI_VALID),
        .TRI_READY (TRI_READY),
        .TRI_DATA  (TRI_DATA),
        .TRI_LAST  (TRI_LAST),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_vec = 0;
    int n_err = 0;

    logic [IW-1:0]       mem_m [DEPTH];
    logic [3*IW:0]       exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] idx(input int b, input int n);
        return mem_m[(b + n) % DEPTH];
    endfunction

    function automatic int tri_count(input int m, input int c);
        int cc;
        cc = (c > DEPTH) ? DEPTH : c;
        if (m == 0) return cc / 3;
        if (m == 1 || m == 2) return (cc >= 3) ? cc - 2 : 0;
        return 0;
    endfunction

    task automatic build_expect(input int m, input int b, input int c);
        int t;
        logic [IW-1:0] v0, v1, v2;
        exp_q.delete();
        t = tri_count(m, c);
        for (int k = 0; k < t; k++) begin
            if (m == 0) begin
                v0 = idx(b, 3*k); v1 = idx(b, 3*k+1); v2 = idx(b, 3*k+2);
            end else if (m == 1) begin
                if (k % 2 == 0) begin
                    v0 = idx(b, k); v1 = idx(b, k+1);
                end else begin
                    v0 = idx(b, k+1); v1 = idx(b, k);
                end
                v2 = idx(b, k+2);
            end else begin
                v0 = idx(b, 0); v1 = idx(b, k+1); v2 = idx(b, k+2);
            end
            exp_q.push_back({(k == t-1), v2, v1, v0});
        end
    endtask

    task automatic host_write(input int a, input int d);
        @(negedge CLK);
        WR_EN   = 1'b1;
        WR_ADDR = AW'(a);
        WR_DATA = IW'(d);
        mem_m[a] = IW'(d);
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    // w0: write issued together with START (same-cycle as the offset-0 read).
    // w1: write issued in the first busy cycle, before the engine reaches it.
    task automatic run_cmd(input string nm, input int m, input int b, input int c,
                           input int rdy_pct, input int hold_first, input bit poke,
                           input bit w0_en, input int w0_a, input int w0_d,
                           input bit w1_en, input int w1_a, input int w1_d);
        int  t, e, o, last_h, ntri, hold;
        bit  waiting, after_hs, done_seen, rdy;
        if (w1_en) mem_m[w1_a] = IW'(w1_d);
        build_expect(m, b, c);
        t = exp_q.size();
        if (w0_en) mem_m[w0_a] = IW'(w0_d);
        @(negedge CLK);
        START = 1'b1; MODE = 2'(m); BASE = AW'(b); COUNT = (AW+1)'(c);
        WR_EN = w0_en; WR_ADDR = AW'(w0_a); WR_DATA = IW'(w0_d);
        e = cyc + 1;
        last_h = e; ntri = 0; hold = 0;
        waiting = 1'b1; after_hs = 1'b0; done_seen = 1'b0;
        for (int it = 0; it < (t + 1) * 30; it++) begin
            @(negedge CLK);
            o = cyc + 1;
            START = poke;
            if (poke) begin
                MODE = 2'd1; BASE = AW'(b + 5); COUNT = (AW+1)'(9);
            end
            WR_EN = (it == 0) && w1_en;
            WR_ADDR = AW'(w1_a); WR_DATA = IW'(w1_d);
            if (it == 0 && t > 0) check_eq({nm, "_busy_rise"}, 64'(BUSY), 64'd1);
            if (after_hs) begin
                check_eq({nm, "_valid_drop"}, 64'(TRI_VALID), 64'd0);
                after_hs = 1'b0;
            end
            if (TRI_VALID) begin
                if (exp_q.size() == 0) begin
                    check_eq({nm, "_extra_tri"}, 64'(TRI_VALID), 64'd0);
                    TRI_READY = 1'b1;
                end else begin
                    if (waiting) begin
                        if (ntri == 0) check_eq({nm, "_first_lat"}, 64'(o - e), 64'd4);
                        else check_eq({nm, "_gap"}, 64'(o - last_h), (m == 0) ? 64'd4 : 64'd2);
                        waiting = 1'b0;
                    end
                    check_eq({nm, "_data"}, 64'(TRI_DATA), 64'(exp_q[0][3*IW-1:0]));
                    check_eq({nm, "_last"}, 64'(TRI_LAST), 64'(exp_q[0][3*IW]));
                    if (ntri == 0 && hold < hold_first) begin
                        hold++;
                        rdy = 1'b0;
                    end else begin
                        rdy = ($urandom_range(0, 99) < rdy_pct);
                    end
                    TRI_READY = rdy;
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        ntri++;
                        last_h = o;
                        waiting = 1'b1;
                        after_hs = 1'b1;
                    end
                end
            end else begin
                TRI_READY = 1'($urandom_range(0, 1));
            end
            if (DONE) begin
                check_eq({nm, "_done_time"}, 64'(o), (t == 0) ? 64'(e + 1) : 64'(last_h + 1));
                check_eq({nm, "_done_busy"}, 64'(BUSY), 64'd0);
                check_eq({nm, "_ntri"}, 64'(ntri), 64'(t));
                START = 1'b0;
                TRI_READY = 1'b0;
                WR_EN = 1'b0;
                done_seen = 1'b1;
                break;
            end
        end
        if (!done_seen) begin
            check_eq({nm, "_timeout"}, 64'd0, 64'd1);
            START = 1'b0;
            TRI_READY = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check_eq({nm, "_busy"},  64'(BUSY),      64'd0);
        check_eq({nm, "_valid"}, 64'(TRI_VALID), 64'd0);
        check_eq({nm, "_data"},  64'(TRI_DATA),  64'd0);
        check_eq({nm, "_last"},  64'(TRI_LAST),  64'd0);
        check_eq({nm, "_done"},  64'(DONE),      64'd0);
    endtask

    initial begin
        int hs;
        bit got;
        int m, b, c;

        RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        START = 1'b0; MODE = '0; BASE = '0; COUNT = '0; TRI_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            WR_EN = 1'b1; WR_ADDR = AW'(i); WR_DATA = IW'($urandom);
            mem_m[i] = WR_DATA;
        end
        @(negedge CLK);
        WR_EN = 1'b0;

        for (int i = 0; i < 7; i++) host_write(i, 10 + i);
        run_cmd("list", 0, 0, 7, 100, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) host_write(100 + i, 1 + i);
        run_cmd("strip", 1, 100, 5, 100, 0, 0, 0, 0, 0, 0, 0, 0);

        host_write(1022, 7); host_write(1023, 8); host_write(0, 9); host_write(1, 6);
        run_cmd("fan_wrap", 2, 1022, 4, 100, 5, 0, 0, 0, 0, 0, 0, 0);

        run_cmd("deg_strip", 1, 0, 2, 100, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cmd("mode3", 3, 0, 9, 100, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cmd("poke", 0, 0, 7, 70, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) host_write(200 + i, 32 + i);
        @(negedge CLK);
        START = 1'b1; MODE = 2'd0; BASE = AW'(200); COUNT = (AW+1)'(12); TRI_READY = 1'b1;
        hs = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (TRI_VALID) begin
                if (hs == 1) got = 1'b1;
                else hs++;
            end
        end
        check_eq("rst_mid_reach", 64'(got), 64'd1);
        RST = 1'b1; TRI_READY = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check_outputs_zero("rst_mid");
        run_cmd("after_rst", 0, 200, 12, 100, 0, 0, 0, 0, 0, 0, 0, 0);

        run_cmd("conc_wr", 1, 300, 6, 100, 0, 0, 1, 300, 16'hdead, 1, 305, 16'hbeef);
        run_cmd("conc_chk", 1, 300, 6, 100, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 25; r++) begin
            m = $urandom_range(0, 3);
            b = $urandom_range(0, DEPTH - 1);
            c = ($urandom_range(0, 9) == 0) ? $urandom_range(1020, 1030) : $urandom_range(0, 24);
            run_cmd("rand", m, b, c, $urandom_range(40, 100), $urandom_range(0, 3), r[0],
                    0, 0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
